// File: rtl/mask_mem_read_m.sv
`default_nettype none
// ============================================================================
// Module      : mask_mem_read_m
// Description : Load-data alignment and extension stage sitting between data
//               memory and MEM/WB write-back. Picks the byte, halfword or word
//               addressed by the load, sign- or zero-extends it to 32 bits and
//               registers it. Also registers a misaligned-access flag for the
//               hazard/exception logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_mem_read_m #(
  parameter int DATA_W = 32          // only 32 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EnableM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [1:0]        MemReadM,
  input  logic [1:0]        AddrLowM,
  input  logic              LoadUnsignedM,
  output logic [DATA_W-1:0] ReadData,
  output logic              MisalignedW
);

  // Load-type encodings carried on MemReadM
  localparam logic [1:0] c_LD_WORD = 2'b00;
  localparam logic [1:0] c_LD_BYTE = 2'b01;
  localparam logic [1:0] c_LD_HALF = 2'b10;
  localparam logic [1:0] c_LD_NONE = 2'b11;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_byteSign;
  logic              w_halfSign;
  logic [DATA_W-1:0] w_loadData;
  logic              w_misaligned;
  logic [DATA_W-1:0] r_readData;
  logic              r_misaligned;

  // Byte-lane and halfword selection (little-endian lanes)
  always_comb begin
    w_byte = ReadDataM[7:0];
    case (AddrLowM)
      2'd0:    w_byte = ReadDataM[7:0];
      2'd1:    w_byte = ReadDataM[15:8];
      2'd2:    w_byte = ReadDataM[23:16];
      default: w_byte = ReadDataM[31:24];
    endcase
    // A misaligned halfword still uses AddrLowM[1] to pick its half
    w_half     = AddrLowM[1] ? ReadDataM[31:16] : ReadDataM[15:0];
    // Unsigned loads force the extension bit to zero
    w_byteSign = w_byte[7]  & ~LoadUnsignedM;
    w_halfSign = w_half[15] & ~LoadUnsignedM;
  end

  // Extension and misalignment detection by load type
  always_comb begin
    w_loadData   = '0;
    w_misaligned = 1'b0;
    case (MemReadM)
      c_LD_WORD: begin
        // Word data passes through unmodified even when misaligned
        w_loadData   = ReadDataM;
        w_misaligned = (AddrLowM != 2'b00);
      end
      c_LD_BYTE: begin
        w_loadData   = {{(DATA_W-8){w_byteSign}}, w_byte};
        w_misaligned = 1'b0;
      end
      c_LD_HALF: begin
        w_loadData   = {{(DATA_W-16){w_halfSign}}, w_half};
        w_misaligned = AddrLowM[0];
      end
      c_LD_NONE: begin
        w_loadData   = '0;
        w_misaligned = 1'b0;
      end
      default: begin
        w_loadData   = '0;
        w_misaligned = 1'b0;
      end
    endcase
  end

  // Output register: reset wins over enable; enable low holds for a stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_readData   <= '0;
      r_misaligned <= 1'b0;
    end else if (EnableM) begin
      r_readData   <= w_loadData;
      r_misaligned <= w_misaligned;
    end
  end

  assign ReadData    = r_readData;
  assign MisalignedW = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mask_mem_read_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_mem_read_m
// Description : Self-checking bench for mask_mem_read_m using a table of
//               directed vectors plus hand-written stall and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_mem_read_m;

  logic        clk;
  logic        rst_n;
  logic        EnableM;
  logic [31:0] ReadDataM;
  logic [1:0]  MemReadM;
  logic [1:0]  AddrLowM;
  logic        LoadUnsignedM;
  logic [31:0] ReadData;
  logic        MisalignedW;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  memRead;
    logic [1:0]  addr;
    logic        uns;
    logic [31:0] expData;
    logic        expMis;
  } vec_t;

  vec_t vecs [22];

  mask_mem_read_m #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EnableM       (EnableM),
    .ReadDataM     (ReadDataM),
    .MemReadM      (MemReadM),
    .AddrLowM      (AddrLowM),
    .LoadUnsignedM (LoadUnsignedM),
    .ReadData      (ReadData),
    .MisalignedW   (MisalignedW)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare both outputs against expected values
  task automatic check(input string name, input logic [31:0] expData, input logic expMis);
    nCompared++;
    if (ReadData !== expData || MisalignedW !== expMis) begin
      nMismatched++;
      $display("FAIL %s: got ReadData=%08h MisalignedW=%b, expected ReadData=%08h MisalignedW=%b",
               name, ReadData, MisalignedW, expData, expMis);
    end
  endtask

  task automatic drive(input logic [31:0] rd, input logic [1:0] mr, input logic [1:0] al, input logic un);
    ReadDataM     = rd;
    MemReadM      = mr;
    AddrLowM      = al;
    LoadUnsignedM = un;
  endtask

  // Wait for the next rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;

    vecs[0]  = '{32'hFFFFFFFF, 2'b00, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 2'b01, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 2'b10, 2'd0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 2'b11, 2'd0, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 2'b00, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 2'b01, 2'd0, 1'b1, 32'h000000FF, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 2'b10, 2'd0, 1'b1, 32'h0000FFFF, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 2'b11, 2'd0, 1'b1, 32'h00000000, 1'b0};
    vecs[8]  = '{32'h80FF7F01, 2'b01, 2'd0, 1'b0, 32'h00000001, 1'b0};
    vecs[9]  = '{32'h80FF7F01, 2'b01, 2'd1, 1'b0, 32'h0000007F, 1'b0};
    vecs[10] = '{32'h80FF7F01, 2'b01, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{32'h80FF7F01, 2'b01, 2'd3, 1'b0, 32'hFFFFFF80, 1'b0};
    vecs[12] = '{32'h80FF7F01, 2'b10, 2'd0, 1'b0, 32'h00007F01, 1'b0};
    vecs[13] = '{32'h80FF7F01, 2'b10, 2'd2, 1'b0, 32'hFFFF80FF, 1'b0};
    vecs[14] = '{32'h80FF7F01, 2'b00, 2'd1, 1'b0, 32'h80FF7F01, 1'b1};
    vecs[15] = '{32'h80FF7F01, 2'b10, 2'd3, 1'b0, 32'hFFFF80FF, 1'b1};
    vecs[16] = '{32'h80FF7F01, 2'b01, 2'd3, 1'b0, 32'hFFFFFF80, 1'b0};
    vecs[17] = '{32'h80FF7F01, 2'b10, 2'd2, 1'b1, 32'h000080FF, 1'b0};
    vecs[18] = '{32'h80FF7F01, 2'b01, 2'd3, 1'b1, 32'h00000080, 1'b0};
    vecs[19] = '{32'h80FF7F01, 2'b11, 2'd1, 1'b0, 32'h00000000, 1'b0};
    vecs[20] = '{32'h80FF7F01, 2'b10, 2'd1, 1'b0, 32'h00007F01, 1'b1};
    vecs[21] = '{32'h80FF7F01, 2'b00, 2'd2, 1'b1, 32'h80FF7F01, 1'b1};

    // Reset with enable asserted and non-zero inputs: reset must win
    rst_n   = 1'b0;
    EnableM = 1'b1;
    drive(32'h80FF7F01, 2'b00, 2'd1, 1'b0);
    step();
    step();
    check("reset", 32'h0, 1'b0);

    // Table-driven vectors, one capture per cycle
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rd, vecs[i].memRead, vecs[i].addr, vecs[i].uns);
      step();
      check($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expMis);
      @(negedge clk);
    end

    // Latency: new inputs must not show before the edge
    drive(32'h12345678, 2'b00, 2'd0, 1'b0);
    #1;
    check("latency_before_edge", 32'h80FF7F01, 1'b1);
    step();
    check("latency_after_edge", 32'h12345678, 1'b0);

    // Stall: three cycles with changing inputs, outputs hold
    @(negedge clk);
    EnableM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hA5A5A5A5 + i, 2'b00, 2'd1, 1'b0);
      step();
      check($sformatf("hold%0d", i), 32'h12345678, 1'b0);
      @(negedge clk);
    end
    EnableM = 1'b1;
    drive(32'hCAFE8001, 2'b10, 2'd0, 1'b0);
    step();
    check("resume", 32'hFFFF8001, 1'b0);

    // Mid-stream reset: clears at the next edge only, then capture resumes
    @(negedge clk);
    drive(32'h80FF7F01, 2'b00, 2'd3, 1'b0);
    step();
    check("pre_reset_capture", 32'h80FF7F01, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'h55AA55AA, 2'b00, 2'd0, 1'b0);
    #1;
    check("reset_not_before_edge", 32'h80FF7F01, 1'b1);
    step();
    check("reset_mid_stream", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_hold", 32'h0, 1'b0);
    step();
    check("post_reset_capture", 32'h55AA55AA, 1'b0);

    // Reset has priority even with enable low
    @(negedge clk);
    rst_n   = 1'b0;
    EnableM = 1'b0;
    step();
    check("reset_over_disable", 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
